control_fsm: RTL and testbench

Control unit for the 8-bit accumulator processor. It consumes the instruction register contents and status flags (`Aeq0`, `Apos`) from the datapath, plus the user `Enter` switch. It produces every datapath control strobe, one Moore state per cycle. It sits directly upstream of the datapath, on the same divided clock, and exposes its state number for the 7-segment display and its halt flag for the LEDs.

---
 rtl/control_fsm_if.sv | 37 +++
 rtl/control_fsm.sv | 169 ++++++++++++++++
 tb/tb_control_fsm.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/control_fsm_if.sv
// Control bus between the accumulator-processor control unit and its datapath.
// master: control unit (consumes opcode and accumulator flags, drives strobes).
// slave:  datapath (drives opcode and flags, consumes strobes).
//   IR[2:0]   opcode field (datapath IR[7:5])
//   Aeq0      accumulator == 0
//   Apos      accumulator > 0
//   IRload    load IR from memory
//   JMPmux    1 = PC source is IR[4:0], 0 = PC+1
//   PCload    load PC
//   Meminst   1 = memory address from PC, 0 = from IR[4:0]
//   MemWr     write A to memory
//   Asel[1:0] A input select: 00 adder/subtractor, 01 Input, 10 memory
//   Aload     load A
//   Sub       1 = subtract, 0 = add
interface control_fsm_if;
  logic [2:0] IR;
  logic       Aeq0;
  logic       Apos;
  logic       IRload;
  logic       JMPmux;
  logic       PCload;
  logic       Meminst;
  logic       MemWr;
  logic [1:0] Asel;
  logic       Aload;
  logic       Sub;

  modport master (
    input  IR, Aeq0, Apos,
    output IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub
  );

  modport slave (
    output IR, Aeq0, Apos,
    input  IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub
  );
endinterface

// File: rtl/control_fsm.sv
// Control unit for the 8-bit accumulator processor: one Moore state per cycle,
// producing every datapath strobe.
//   Clock        divided processor clock, rising edge
//   Reset        synchronous active-low; 0 forces START and clears the Enter synchronizer
//   Enter        asynchronous user switch (level), synchronized internally
//   bus          control bus (master side): opcode/flags in, strobes out
//   Halt         processor halted
//   outputState  current state code for the 7-segment display
module control_fsm #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Enter,
  control_fsm_if.master       bus,
  output logic                Halt,
  output logic [3:0]          outputState
);

  typedef enum logic [3:0] {
    StStart  = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StLoad   = 4'd3,
    StStore  = 4'd4,
    StAdd    = 4'd5,
    StSub    = 4'd6,
    StIn     = 4'd7,
    StInrel  = 4'd8,
    StJz     = 4'd9,
    StJpos   = 4'd10,
    StHalt   = 4'd11
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   enter_s, enter_s_d;

  // Registered strobes, computed from the next state so they line up with state_q.
  logic       irload_q, irload_d;
  logic       jmpmux_q, jmpmux_d;
  logic       pcload_q, pcload_d;
  logic       meminst_q, meminst_d;
  logic       memwr_q, memwr_d;
  logic [1:0] asel_q, asel_d;
  logic       aload_q, aload_d;
  logic       sub_q, sub_d;
  logic       halt_q, halt_d;
  logic       jz_q, jz_d;
  logic       jpos_q, jpos_d;

  assign enter_s   = sync_q[SYNC_STAGES-1];
  // Value enter_s will hold after the coming edge.
  assign enter_s_d = sync_q[SYNC_STAGES-2];

  always_comb begin
    state_d = StStart;
    unique case (state_q)
      StStart:  state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: begin
        unique case (bus.IR)
          3'b000:  state_d = StLoad;
          3'b001:  state_d = StStore;
          3'b010:  state_d = StAdd;
          3'b011:  state_d = StSub;
          3'b100:  state_d = StIn;
          3'b101:  state_d = StJz;
          3'b110:  state_d = StJpos;
          default: state_d = StHalt;
        endcase
      end
      StIn:     state_d = enter_s ? StInrel : StIn;
      StInrel:  state_d = enter_s ? StInrel : StStart;
      StHalt:   state_d = StHalt;
      default:  state_d = StStart;
    endcase
  end

  always_comb begin
    irload_d  = 1'b0;
    jmpmux_d  = 1'b0;
    pcload_d  = 1'b0;
    meminst_d = 1'b0;
    memwr_d   = 1'b0;
    asel_d    = 2'b00;
    aload_d   = 1'b0;
    sub_d     = 1'b0;
    halt_d    = 1'b0;
    jz_d      = 1'b0;
    jpos_d    = 1'b0;
    unique case (state_d)
      StFetch: begin
        meminst_d = 1'b1;
        irload_d  = 1'b1;
        pcload_d  = 1'b1;
      end
      StLoad: begin
        asel_d  = 2'b10;
        aload_d = 1'b1;
      end
      StStore: memwr_d = 1'b1;
      StAdd:   aload_d = 1'b1;
      StSub: begin
        aload_d = 1'b1;
        sub_d   = 1'b1;
      end
      StIn: begin
        asel_d  = 2'b01;
        aload_d = enter_s_d;
      end
      StJz: begin
        jmpmux_d = 1'b1;
        jz_d     = 1'b1;
      end
      StJpos: begin
        jmpmux_d = 1'b1;
        jpos_d   = 1'b1;
      end
      StHalt:  halt_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q   <= StStart;
      sync_q    <= '0;
      irload_q  <= 1'b0;
      jmpmux_q  <= 1'b0;
      pcload_q  <= 1'b0;
      meminst_q <= 1'b0;
      memwr_q   <= 1'b0;
      asel_q    <= 2'b00;
      aload_q   <= 1'b0;
      sub_q     <= 1'b0;
      halt_q    <= 1'b0;
      jz_q      <= 1'b0;
      jpos_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], Enter};
      irload_q  <= irload_d;
      jmpmux_q  <= jmpmux_d;
      pcload_q  <= pcload_d;
      meminst_q <= meminst_d;
      memwr_q   <= memwr_d;
      asel_q    <= asel_d;
      aload_q   <= aload_d;
      sub_q     <= sub_d;
      halt_q    <= halt_d;
      jz_q      <= jz_d;
      jpos_q    <= jpos_d;
    end
  end

  assign bus.IRload  = irload_q;
  assign bus.JMPmux  = jmpmux_q;
  // Jump decision uses the live flags in the JZ/JPOS cycle.
  assign bus.PCload  = pcload_q | (jz_q & bus.Aeq0) | (jpos_q & bus.Apos);
  assign bus.Meminst = meminst_q;
  assign bus.MemWr   = memwr_q;
  assign bus.Asel    = asel_q;
  assign bus.Aload   = aload_q;
  assign bus.Sub     = sub_q;
  assign Halt        = halt_q;
  assign outputState = state_q;

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;
  localparam int SYNC = 2;

  // Strobe word layout: IRload JMPmux PCload Meminst MemWr Asel[1:0] Aload Sub Halt
  localparam logic [9:0] SFetch = 10'b1011000000;
  localparam logic [9:0] SLoad  = 10'b0000010100;
  localparam logic [9:0] SStore = 10'b0000100000;
  localparam logic [9:0] SAdd   = 10'b0000000100;
  localparam logic [9:0] SSub   = 10'b0000000110;
  localparam logic [9:0] SIn    = 10'b0000001000;
  localparam logic [9:0] SInLd  = 10'b0000001100;
  localparam logic [9:0] SJmp   = 10'b0100000000;
  localparam logic [9:0] SJmpT  = 10'b0110000000;
  localparam logic [9:0] SHalt  = 10'b0000000001;
  localparam logic [9:0] SNone  = 10'b0000000000;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Enter;
  logic       Halt;
  logic [3:0] outputState;

  control_fsm_if bus ();

  control_fsm #(.SYNC_STAGES(SYNC)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Enter       (Enter),
    .bus         (bus),
    .Halt        (Halt),
    .outputState (outputState)
  );

  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;

  // Reference model: state number plus a delay line of Enter samples.
  int   m_st = 0;
  logic enter_hist[$];
  logic [9:0] base_str[16];

  function automatic logic [9:0] strobes();
    return {bus.IRload, bus.JMPmux, bus.PCload, bus.Meminst, bus.MemWr, bus.Asel,
            bus.Aload, bus.Sub, Halt};
  endfunction

  function automatic logic model_enter_s();
    return (enter_hist.size() == SYNC) ? enter_hist[0] : 1'b0;
  endfunction

  function automatic logic [9:0] model_str();
    logic [9:0] s;
    s = base_str[m_st];
    if (m_st == 7 && model_enter_s()) s[2] = 1'b1;
    if (m_st == 9 && bus.Aeq0) s[7] = 1'b1;
    if (m_st == 10 && bus.Apos) s[7] = 1'b1;
    return s;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge; the model advances using the inputs held across the edge.
  task automatic step();
    logic es;
    int op;
    @(posedge Clock);
    es = model_enter_s();
    op = int'(bus.IR);
    if (!Reset) begin
      m_st = 0;
      enter_hist.delete();
    end else begin
      case (m_st)
        0: m_st = 1;
        1: m_st = 2;
        2: m_st = (op <= 4) ? op + 3 : op + 4;
        7: m_st = es ? 8 : 7;
        8: m_st = es ? 8 : 0;
        11: m_st = 11;
        default: m_st = 0;
      endcase
      enter_hist.push_back(Enter);
      if (enter_hist.size() > SYNC) void'(enter_hist.pop_front());
    end
    #1;
  endtask

  task automatic chk_out(input string name, input int st, input logic [9:0] s);
    chk({name, ".state"}, 16'(outputState), 16'(st));
    chk({name, ".strobes"}, 16'(strobes()), 16'(s));
  endtask

  typedef struct {
    string      name;
    logic [2:0] ir;
    logic       aeq0;
    logic       apos;
    int         st;
    logic [9:0] s;
  } vec_t;

  vec_t vecs[8];

  initial begin
    foreach (base_str[i]) base_str[i] = SNone;
    base_str[1]  = SFetch;
    base_str[3]  = SLoad;
    base_str[4]  = SStore;
    base_str[5]  = SAdd;
    base_str[6]  = SSub;
    base_str[7]  = SIn;
    base_str[9]  = SJmp;
    base_str[10] = SJmp;
    base_str[11] = SHalt;

    vecs[0] = '{"load",   3'b000, 1'b0, 1'b0, 3,  SLoad};
    vecs[1] = '{"store",  3'b001, 1'b0, 1'b0, 4,  SStore};
    vecs[2] = '{"add",    3'b010, 1'b1, 1'b0, 5,  SAdd};
    vecs[3] = '{"sub",    3'b011, 1'b0, 1'b1, 6,  SSub};
    vecs[4] = '{"jz_t",   3'b101, 1'b1, 1'b0, 9,  SJmpT};
    vecs[5] = '{"jz_n",   3'b101, 1'b0, 1'b1, 9,  SJmp};
    vecs[6] = '{"jpos_t", 3'b110, 1'b0, 1'b1, 10, SJmpT};
    vecs[7] = '{"jpos_n", 3'b110, 1'b1, 1'b0, 10, SJmp};

    Reset = 1'b0;
    Enter = 1'b0;
    bus.IR = 3'b000;
    bus.Aeq0 = 1'b0;
    bus.Apos = 1'b0;
    step();
    chk_out("reset", 0, SNone);

    // Table-driven single instructions from reset.
    for (int i = 0; i < 8; i++) begin
      Reset = 1'b0;
      bus.IR = vecs[i].ir;
      bus.Aeq0 = vecs[i].aeq0;
      bus.Apos = vecs[i].apos;
      step();
      chk_out({vecs[i].name, ".start"}, 0, SNone);
      Reset = 1'b1;
      step();
      chk_out({vecs[i].name, ".fetch"}, 1, SFetch);
      step();
      chk_out({vecs[i].name, ".decode"}, 2, SNone);
      step();
      chk_out({vecs[i].name, ".exec"}, vecs[i].st, vecs[i].s);
      step();
      chk_out({vecs[i].name, ".back"}, 0, SNone);
    end

    // IN: reset held from IN, then wait, press, hold, release.
    bus.IR = 3'b100;
    repeat (3) step();
    chk_out("in.reach", 7, SIn);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("in.reset", 0, SNone);
    end
    Reset = 1'b1;
    step();
    chk_out("in.rel1", 1, SFetch);
    step();
    chk_out("in.rel2", 2, SNone);
    step();
    chk_out("in.rel3", 7, SIn);
    for (int i = 0; i < 10; i++) begin
      step();
      chk_out("in.wait", 7, SIn);
    end
    Enter = 1'b1;
    step();
    chk_out("in.press1", 7, SIn);
    step();
    chk_out("in.press2", 7, SInLd);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("in.hold", 8, SNone);
    end
    Enter = 1'b0;
    step();
    chk_out("in.drop1", 8, SNone);
    step();
    chk_out("in.drop2", 8, SNone);
    step();
    chk_out("in.done", 0, SNone);

    // Enter already high when IN is entered: immediate load.
    Enter = 1'b1;
    repeat (3) step();
    chk_out("in.early", 7, SInLd);
    step();
    chk_out("in.early_rel", 8, SNone);
    Enter = 1'b0;
    repeat (3) step();
    chk_out("in.early_done", 0, SNone);

    // HALT holds until reset.
    bus.IR = 3'b111;
    repeat (4) step();
    for (int i = 0; i < 20; i++) begin
      step();
      chk_out("halt.hold", 11, SHalt);
    end
    Reset = 1'b0;
    step();
    chk_out("halt.reset", 0, SNone);

    // Reset in DECODE of STORE: no MemWr.
    Reset = 1'b1;
    bus.IR = 3'b001;
    step();
    step();
    chk_out("st_abort.decode", 2, SNone);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_abort.memwr", 16'(bus.MemWr), 16'd0);
      chk("st_abort.state", 16'(outputState), 16'd0);
    end

    // Randomized run against the model.
    for (int i = 0; i < 1500; i++) begin
      Reset = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 5) == 0) Enter = ~Enter;
      bus.IR = 3'($urandom_range(0, 7));
      bus.Aeq0 = 1'($urandom_range(0, 1));
      bus.Apos = 1'($urandom_range(0, 1));
      step();
      chk("rand.state", 16'(outputState), 16'(m_st));
      chk("rand.strobes", 16'(strobes()), 16'(model_str()));
      // Flags change mid-cycle; the jump gating must follow them.
      bus.Aeq0 = ~bus.Aeq0;
      bus.Apos = ~bus.Apos;
      #1;
      chk("rand.live", 16'(strobes()), 16'(model_str()));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
